// File: rtl/cbus_arbiter_if.sv
// CBus request/response types and the bus interface that bundles them.
// A "master" drives a request and receives a response; a "slave" does the
// reverse. The arbiter is a slave towards both CPU-side masters and a
// master towards the CBus-to-AXI converter.
package cbus_pkg;

   typedef struct packed {
      logic        valid;
      logic        is_write;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [3:0]  strobe;
      logic [31:0] data;
      logic [3:0]  len;
   } cbus_req_t;

   typedef struct packed {
      logic        ready;
      logic        last;
      logic [31:0] data;
   } cbus_resp_t;

endpackage

interface cbus_if;
   import cbus_pkg::*;

   cbus_req_t  req;
   cbus_resp_t resp;

   modport master (output req, input  resp);
   modport slave  (input  req, output resp);
endinterface

// File: rtl/cbus_arbiter.sv
// Two-master CBus arbiter. The instruction (ibus) and data (dbus) masters
// share one downstream CBus port (obus). A grant is decided in IDLE,
// registered, and held until the converter returns the beat with last=1.
// Ties are broken round-robin; INIT_PRIO picks the winner of the first
// tie after reset. Responses pass through combinationally, so the arbiter
// adds no latency to data beats.
module cbus_arbiter
   import cbus_pkg::*;
#(
   parameter bit INIT_PRIO = 1'b1   // 0 = instruction, 1 = data
) (
   input  logic    clk,
   input  logic    resetn,
   cbus_if.slave   ibus,
   cbus_if.slave   dbus,
   cbus_if.master  obus
);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t r_state;
   state_t w_state_nxt;
   logic   r_owner;        // 0 = instruction, 1 = data
   logic   w_owner_nxt;
   logic   r_last;         // master granted by the most recent completed transaction
   logic   w_last_nxt;
   logic   w_beat_done;

   assign w_beat_done = obus.resp.ready && obus.resp.last;

   // State, owner and last-granted registers; reset abandons any transaction.
   // NOTE: non-blocking assignments here so every register samples the
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= IDLE;
         r_owner <= 1'b0;
         r_last  <= ~INIT_PRIO;
      end else begin
         r_state <= w_state_nxt;
         r_owner <= w_owner_nxt;
         r_last  <= w_last_nxt;
      end
   end

   // Next-state: grant in IDLE (round-robin on a tie), release on the last beat.
   // NOTE: every output gets a default first, so no path can infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_owner_nxt = r_owner;
      w_last_nxt  = r_last;
      case (r_state)
         IDLE: begin
            if (ibus.req.valid || dbus.req.valid) begin
               w_state_nxt = BUSY;
               if (ibus.req.valid && dbus.req.valid) begin
                  w_owner_nxt = ~r_last;
               end else begin
                  w_owner_nxt = dbus.req.valid;
               end
            end
         end
         BUSY: begin
            // The owner's valid is deliberately ignored: only last ends a burst.
            if (w_beat_done) begin
               w_state_nxt = IDLE;
               w_last_nxt  = r_owner;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Datapath: forward the owner's request and route the response back to it.
   always_comb begin
      obus.req  = '0;
      ibus.resp = '0;
      dbus.resp = '0;
      if (r_state == BUSY) begin
         if (r_owner) begin
            obus.req  = dbus.req;
            dbus.resp = obus.resp;
         end else begin
            obus.req  = ibus.req;
            ibus.resp = obus.resp;
         end
      end
   end

endmodule

// File: tb/tb_cbus_arbiter.sv
// Self-checking bench for cbus_arbiter. A transaction-level model tracks
// which master (if any) holds the bus and who was granted last; expected
// outputs are derived from it every cycle, alongside directed checks.
module tb_cbus_arbiter;
   import cbus_pkg::*;

   localparam bit INIT_PRIO = 1'b1;

   logic clk = 1'b0;
   logic resetn;

   cbus_if ibus ();
   cbus_if dbus ();
   cbus_if obus ();

   cbus_arbiter #(.INIT_PRIO(INIT_PRIO)) dut (
      .clk    (clk),
      .resetn (resetn),
      .ibus   (ibus),
      .dbus   (dbus),
      .obus   (obus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int i_beats  = 0;
   int d_beats  = 0;

   // Reference model: -1 = nobody owns the bus, 0 = instruction, 1 = data.
   int m_owner = -1;
   int m_last  = 0;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   task automatic model_reset();
      m_owner = -1;
      m_last  = INIT_PRIO ? 0 : 1;
   endtask

   // Applies the arbitration rules to the inputs present at a clock edge.
   task automatic model_update();
      if (!resetn) begin
         model_reset();
      end else if (m_owner < 0) begin
         if (ibus.req.valid && dbus.req.valid) m_owner = 1 - m_last;
         else if (ibus.req.valid)             m_owner = 0;
         else if (dbus.req.valid)             m_owner = 1;
      end else if (obus.resp.ready && obus.resp.last) begin
         m_last  = m_owner;
         m_owner = -1;
      end
   endtask

   task automatic check_outputs();
      cbus_req_t  er;
      cbus_resp_t ei;
      cbus_resp_t ed;
      er = '0;
      ei = '0;
      ed = '0;
      if (m_owner == 0) begin
         er = ibus.req;
         ei = obus.resp;
      end else if (m_owner == 1) begin
         er = dbus.req;
         ed = obus.resp;
      end
      check("oreq",  obus.req,  er);
      check("iresp", ibus.resp, ei);
      check("dresp", dbus.resp, ed);
      check("one_ready", ibus.resp.ready & dbus.resp.ready, 1'b0);
      if (m_owner < 0) check("idle_ovalid", obus.req.valid, 1'b0);
   endtask

   // One clock: settle, check, count delivered beats, advance DUT and model.
   task automatic tick();
      #1;
      check_outputs();
      if (ibus.resp.ready) i_beats++;
      if (dbus.resp.ready) d_beats++;
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      model_reset();
      tick();
      tick();
      resetn = 1'b1;
   endtask

   function automatic cbus_req_t mk_req(input bit wr, input logic [31:0] addr,
                                        input logic [3:0] strobe, input logic [31:0] data,
                                        input logic [3:0] len);
      cbus_req_t r;
      r.valid    = 1'b1;
      r.is_write = wr;
      r.size     = 3'd2;
      r.addr     = addr;
      r.strobe   = strobe;
      r.data     = data;
      r.len      = len;
      return r;
   endfunction

   // Waits (bounded) for a grant, checks the winner, serves `beats` beats
   // with one stall cycle after the first, then checks the turnaround.
   task automatic run_txn(input string tag, input int exp_owner, input int beats);
      int        i0;
      int        d0;
      cbus_req_t exp_req;
      #1;
      for (int k = 0; k < 8 && obus.req.valid !== 1'b1; k++) tick();
      check({tag, "_granted"}, obus.req.valid, 1'b1);
      exp_req = (exp_owner == 1) ? dbus.req : ibus.req;
      check({tag, "_owner"}, obus.req, exp_req);
      i0 = i_beats;
      d0 = d_beats;
      for (int b = 0; b < beats; b++) begin
         if (b == 1) begin
            obus.resp = '0;
            tick();
         end
         obus.resp.ready = 1'b1;
         obus.resp.last  = (b == beats - 1);
         obus.resp.data  = $urandom;
         tick();
      end
      obus.resp = '0;
      #1;
      check({tag, "_turnaround"}, obus.req.valid, 1'b0);
      check({tag, "_ibeats"}, i_beats - i0, (exp_owner == 0) ? beats : 0);
      check({tag, "_dbeats"}, d_beats - d0, (exp_owner == 1) ? beats : 0);
   endtask

   initial begin
      int i0;
      int d0;
      ibus.req  = '0;
      dbus.req  = '0;
      obus.resp = '0;

      // Reset: everything quiet while held and right after release.
      do_reset();
      #1;
      check("rst_oreq",  obus.req,  '0);
      check("rst_iresp", ibus.resp, '0);
      check("rst_dresp", dbus.resp, '0);

      // Single instruction fetch, last returned on the second BUSY cycle.
      i_beats  = 0;
      ibus.req = mk_req(1'b0, 32'hBFC0_0000, 4'hF, 32'h0, 4'd0);
      tick();                                    // cycle 1: IDLE, grant registered
      check("t1_c1_hold", m_owner, 0);
      check("t1_c2_valid", obus.req.valid, 1'b1);
      check("t1_c2_addr",  obus.req.addr, 32'hBFC0_0000);
      tick();                                    // cycle 2: BUSY, no response yet
      obus.resp = '{ready: 1'b1, last: 1'b1, data: 32'hCAFE_0001};
      tick();                                    // cycle 3: the only beat
      obus.resp = '0;
      ibus.req  = '0;
      check("t1_c4_idle",  obus.req.valid, 1'b0);
      check("t1_ibeats",   i_beats, 1);

      // Round-robin after reset: data, inst, data with both always valid.
      do_reset();
      ibus.req = mk_req(1'b0, 32'h0000_1000, 4'hF, 32'h0, 4'd0);
      dbus.req = mk_req(1'b0, 32'h8000_2000, 4'hF, 32'h0, 4'd0);
      run_txn("rr1_data", 1, 1);
      run_txn("rr2_inst", 0, 1);
      run_txn("rr3_data", 1, 1);

      // Data burst of 4 beats with the instruction master waiting throughout.
      ibus.req = '0;
      dbus.req = mk_req(1'b0, 32'h8000_3000, 4'hF, 32'h0, 4'd3);
      tick();
      ibus.req = mk_req(1'b0, 32'h0000_3000, 4'hF, 32'h0, 4'd0);
      run_txn("burst", 1, 4);
      dbus.req = '0;
      run_txn("after_burst", 0, 1);

      // Data write: payload forwarded bit-for-bit, instruction side silent.
      ibus.req = '0;
      dbus.req = mk_req(1'b1, 32'h8000_4000, 4'b0011, 32'h1234_5678, 4'd0);
      tick();
      check("wr_is_write", obus.req.is_write, 1'b1);
      check("wr_strobe",   obus.req.strobe, 4'b0011);
      check("wr_data",     obus.req.data, 32'h1234_5678);
      check("wr_iresp",    ibus.resp, '0);
      run_txn("wr", 1, 1);

      // Reset on beat 2 of a 4-beat read: abandon, then arbitrate fresh.
      dbus.req = mk_req(1'b0, 32'h8000_5000, 4'hF, 32'h0, 4'd3);
      tick();
      d0 = d_beats;
      obus.resp = '{ready: 1'b1, last: 1'b0, data: 32'h0000_0B01};
      tick();                                    // beat 1 delivered
      obus.resp = '{ready: 1'b1, last: 1'b0, data: 32'h0000_0B02};
      resetn = 1'b0;
      #1;
      model_reset();
      check("mid_rst_oreq",  obus.req,  '0);
      check("mid_rst_dresp", dbus.resp, '0);
      check("mid_rst_iresp", ibus.resp, '0);
      tick();
      resetn   = 1'b1;
      dbus.req = '0;
      ibus.req = mk_req(1'b0, 32'hBFC0_0100, 4'hF, 32'h0, 4'd0);
      i0 = i_beats;
      tick();                                    // IDLE after release, converter still ready
      check("post_rst_dbeats", d_beats - d0, 1);
      check("post_rst_ibeats", i_beats - i0, 0);
      obus.resp = '0;
      run_txn("post_rst", 0, 1);

      // Random traffic: arbitrary valids, payloads and converter responses.
      ibus.req = '0;
      dbus.req = '0;
      for (int n = 0; n < 400; n++) begin
         cbus_req_t  ri;
         cbus_req_t  rd;
         cbus_resp_t rr;
         ri = mk_req($urandom_range(0, 1) == 1, $urandom, 4'($urandom), $urandom, 4'($urandom));
         rd = mk_req($urandom_range(0, 1) == 1, $urandom, 4'($urandom), $urandom, 4'($urandom));
         ri.valid = ($urandom_range(0, 9) < 6);
         rd.valid = ($urandom_range(0, 9) < 6);
         rr.ready = ($urandom_range(0, 3) != 0);
         rr.last  = ($urandom_range(0, 2) == 0);
         rr.data  = $urandom;
         ibus.req  = ri;
         dbus.req  = rd;
         obus.resp = rr;
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cbus_arbiter.md
CBUS_ARBITER -- requirements
Module: cbus_arbiter

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, rising-edge; resetn  in  1  asynchronous, active-low reset.
REQ-002 SHALL have ireq  in  cbus_req_t  instruction-side master request; iresp  out  cbus_resp_t  its response.
REQ-003 SHALL have dreq  in  cbus_req_t  data-side master request; dresp  out  cbus_resp_t  its response.
REQ-004 SHALL have oreq  out  cbus_req_t  to the CBus-to-AXI converter; oresp  in  cbus_resp_t  from it.
REQ-005 SHALL use these cbus_req_t fields: valid 1, is_write 1, size 3, addr 32, strobe 4, data 32, len 4. SHALL use these cbus_resp_t fields: ready 1, last 1, data 32.
REQ-006 SHALL have parameter INIT_PRIO, default 1, index of the master favoured on the first arbitration after reset (0 = instruction, 1 = data).

Function
REQ-007 SHALL implement a 2-state FSM, IDLE and BUSY, plus a 1-bit owner register and a 1-bit last-granted register.
REQ-008 IDLE with neither ireq.valid nor dreq.valid -> SHALL stay in IDLE, drive oreq all-zero, and drive iresp and dresp all-zero.
REQ-009 IDLE with exactly one master valid -> SHALL set owner to that master and enter BUSY on the next edge.
REQ-010 IDLE with both valid -> SHALL grant the master that is not the last-granted one (round-robin). On the first grant after reset, SHALL grant master INIT_PRIO.
REQ-011 In IDLE, oreq SHALL stay zero; the grant decision is registered, with no combinational pass-through in the granting cycle.
REQ-012 In BUSY, oreq SHALL equal the owner's request and the owner's resp SHALL equal oresp. The non-owner's resp SHALL be all-zero, so ready=0 and the non-owner stalls.
REQ-013 In BUSY, when oresp.ready && oresp.last -> SHALL return to IDLE on that edge and set last-granted to owner.
REQ-014 Burst transactions (len > 0) SHALL stay locked to the owner until the beat with last=1. Intermediate ready beats SHALL NOT release the bus.
REQ-015 Minimum turnaround is one IDLE cycle between the last beat of one transaction and oreq.valid of the next.
REQ-016 Masters hold their request stable until the last beat; the arbiter does not latch request payload, only owner.
REQ-017 If the owner deasserts valid while BUSY (protocol violation), the arbiter SHALL still forward the request and stay BUSY until ready && last.
REQ-018 Write and read transactions SHALL be arbitrated identically; is_write does not affect priority.
REQ-019 The arbiter SHALL add zero latency to response beats: the resp is combinational from oresp in BUSY.

Reset
REQ-020 On resetn=0, the FSM SHALL go to IDLE asynchronously, owner SHALL become 0, and last-granted SHALL become !INIT_PRIO.
REQ-021 While in reset and immediately after, oreq, iresp and dresp SHALL be all-zero.
REQ-022 Reset asserted mid-transaction SHALL abandon the transaction without any further beats being forwarded. The first transaction after release is arbitrated fresh.

Verification
REQ-023 Reset, then ireq.valid only, addr=0xBFC0_0000, len=0, and oresp ready+last returned on the 2nd BUSY cycle -> oreq.valid=1 from cycle 2 to cycle 3, iresp.ready=1 exactly once, FSM back in IDLE at cycle 4.
REQ-024 Both masters valid right after reset (INIT_PRIO=1) -> data is granted first. After its last beat plus one IDLE cycle, the instruction master is granted. Repeating with both valid alternates data, inst, data.
REQ-025 Data burst len=3 (4 beats), with ireq valid throughout -> all 4 beats go to dresp only, and iresp.ready stays 0. The instruction master is granted only after the beat with last=1.
REQ-026 Data write, is_write=1, strobe=4'b0011, data=0x1234_5678 -> oreq matches dreq bit-for-bit while BUSY, and iresp stays zero.
REQ-027 resetn pulled low on beat 2 of a 4-beat read -> outputs go zero immediately. After release, a new ireq is granted with INIT_PRIO rules and no stale beats are delivered.
REQ-028 A bench SHALL check on every cycle that at most one of iresp.ready and dresp.ready is 1, and that oreq.valid=0 whenever the FSM is in IDLE.
